// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle log-stage shifter sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } seq_state_e;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift_stage_mux.sv
// One stage of the log shifter: conditionally shifts by 2^stage_i with op-specific fill.
module shift_stage_mux
  import shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = $clog2(WIDTH),
  localparam int CW    = $clog2(SHW)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    stage_i,
  input  logic             en_i,
  input  logic [1:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] fill_w;
  logic [WIDTH-1:0] left_w;
  logic [WIDTH-1:0] right_w;

  // Right shifts pull bits from an upper word: zeros, sign copies, or the data itself (rotate).
  always_comb begin
    fill_w = '0;
    case (shift_op_e'(op_i))
      SRA:     fill_w = {WIDTH{sign_i}};
      ROR:     fill_w = data_i;
      default: fill_w = '0;
    endcase
  end

  assign left_w  = data_i << (1 << stage_i);
  assign right_w = WIDTH'({fill_w, data_i} >> (1 << stage_i));

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = (shift_op_e'(op_i) == SLL) ? left_w : right_w;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer applying one log-shifter stage per clock; one operation in flight, valid/ready both sides.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = $clog2(WIDTH),
  localparam int CW    = $clog2(SHW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic             vld_q, busy_q;
  logic [WIDTH-1:0] stage_res;
  logic             last_stage;

  assign last_stage = (cnt_q == CW'(SHW - 1));

  shift_stage_mux #(.WIDTH(WIDTH)) u_stage (
    .data_i  (data_q),
    .stage_i (cnt_q),
    .en_i    (shamt_q[cnt_q]),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .data_o  (stage_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    res_d   = res_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_a;
          shamt_d = in_shamt;
          op_d    = in_op;
          sign_d  = in_a[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          data_d = stage_res;
          cnt_d  = cnt_q + CW'(1);
          if (last_stage) begin
            res_d   = stage_res;
            cnt_d   = '0;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        // abort wins over out_ready: either way we leave, but the result is treated as dropped.
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      res_q   <= res_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      vld_q   <= (state_d == OUT);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = vld_q;
  assign busy       = busy_q;
  assign out_result = res_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: vector table plus hand-written handshake, abort and reset sequences.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shift_seq_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Full operation with out_ready high: checks accept, latency, result and return to idle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                       input logic [31:0] exp, input string nm);
    int cycles;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_shamt  = sh;
    chk({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({nm, "_in_ready_shift"}, 32'(in_ready), 32'd0);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk({nm, "_latency"}, 32'(cycles), 32'd5);
    chk({nm, "_result"}, out_result, exp);
    chk({nm, "_busy_out"}, 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({nm, "_busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc[$];
    int cycles;
    bit seen;

    vecs[0] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl31"};
    vecs[1] = '{2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, "sra4"};
    vecs[2] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, "sra31_pos"};
    vecs[3] = '{2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, "sll0"};
    vecs[4] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31"};
    vecs[5] = '{2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, "ror8"};
    vecs[6] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31_neg"};
    vecs[7] = '{2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000, "ror1"};
    vecs[8] = '{2'b00, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFE0, "sll5"};
    vecs[9] = '{2'b01, 32'hF000_0000, 5'd3,  32'h1E00_0000, "srl3"};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0;
    abort = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].sh, vecs[i].exp, vecs[i].nm);

    // Back-to-back: in_valid held high, accepts must be 7 cycles apart.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b11; in_a = 32'h1234_5678; in_shamt = 5'd8;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ready) acc.push_back(c);
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_interval", 32'(acc[i] - acc[i-1]), 32'd7);
    chk("b2b_last_result", out_result, 32'h7812_3456);

    // Backpressure: hold OUT for 3 cycles with a competing request.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b10; in_a = 32'h8000_00F0; in_shamt = 5'd4;
    @(posedge clk);
    @(negedge clk);
    in_a = 32'h0000_0055; in_op = 2'b00; in_shamt = 5'd1;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("bp_latency", 32'(cycles), 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_result_hold", out_result, 32'hF800_000F);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_valid_still", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_not_accepted", 32'(busy), 32'd0);

    // Abort during stage 2.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'hFFFF_0000; in_shamt = 5'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_valid", 32'(seen), 32'd0);

    // Abort in IDLE is ignored and the simultaneous request is accepted.
    in_valid = 1'b1; abort = 1'b1; in_op = 2'b00; in_a = 32'h0000_0003; in_shamt = 5'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_accept", 32'(busy), 32'd1);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("idle_abort_latency", 32'(cycles), 32'd5);
    chk("idle_abort_result", out_result, 32'h0000_000C);
    @(negedge clk);

    // Asynchronous reset during stage 3, then a clean operation.
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'h8000_0000; in_shamt = 5'd31;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, "post_rst_ror8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the log-stage shifter datapath; one shift stage (1, 2, 4, 8, 16) is applied per clock.
- Supports SLL, SRL, SRA and ROR, selected per operation.
- Sits between the ALU issue logic and the writeback mux.
- Used where a single-cycle 32-bit barrel shifter breaks timing.
- Valid/ready on the input and output sides; one operation in flight.

Parameters:
- WIDTH, 32, datapath width. Power of two, >= 8.
- SHW is a derived localparam, $clog2(WIDTH), not overridable. It sets the shamt width and the stage count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  controller can accept a request
- in_a  input  WIDTH  operand
- in_shamt  input  SHW  shift amount
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- abort  input  1  synchronous cancel of the in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_result  output  WIDTH  shifted value
- busy  output  1  high in SHIFT or OUT

Behaviour:
- States: IDLE, SHIFT, OUT.
- Reset (asynchronous, immediate, mid-operation included):
  - state IDLE; stage counter 0; data register 0; op/shamt registers 0.
  - out_valid 0, out_result 0, busy 0; in_ready 1.
- IDLE:
  - in_ready = 1.
  - On in_valid at the edge (accept edge E0): latch in_a, in_shamt, in_op; stage counter 0; go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - At each edge, stage k = counter applies a shift of 2^k if shamt_reg[k] = 1, else passes through; counter increments.
  - After stage SHW-1 (edge E5 for WIDTH=32), go to OUT.
  - Latency is fixed at SHW stage edges, independent of shamt value. shamt=0 still takes 5 cycles.
- Stage fill rules:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the original bit WIDTH-1 enter at the MSB.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- OUT:
  - out_valid = 1; out_result = data register, held stable until handshake.
  - On out_ready at the edge, go to IDLE.
  - No accept in the same cycle as the output handshake. Minimum issue interval is 7 cycles (E0 accept, E1-E5 stages, E6 handshake, E7 next accept).
- out_result outside OUT: holds its last value, but is valid only while out_valid = 1.
- abort:
  - In SHIFT or OUT: go to IDLE at the next edge. Result discarded; out_valid drops after that edge.
  - abort has priority over out_ready in the same cycle; the result counts as not delivered.
  - In IDLE: ignored, and an in_valid in that cycle is still accepted.
- in_valid while not IDLE: ignored, no state change; the requester must hold it.
- Registered outputs: out_valid, busy, out_result.
- Combinational output: in_ready = (state == IDLE), so it reads 1 during reset.

Decomposition:
- Shared package shift_pkg:
  - shift_op_e enum (SLL=2'b00, SRL=2'b01, SRA=2'b10, ROR=2'b11).
  - seq_state_e enum (IDLE, SHIFT, OUT).
  - localparam DEFAULT_WIDTH = 32.
- Sub-module shift_stage_mux (combinational):
  - Inputs: data, stage index, enable bit, op, fill sign bit.
  - Output: one stage's result.
  - The controller instantiates it once and feeds back through the data register.

Test Plan:
1. SRL in_a=0x8000_0000, shamt=31, out_ready=1 -> out_result=0x0000_0001; out_valid first high in the cycle after E5; busy high from E0 until the E6 handshake.
2. SRA in_a=0x8000_00F0, shamt=4 -> 0xF800_000F. Then SRA in_a=0x7FFF_FFFF, shamt=31 -> 0x0000_0000.
3. SLL in_a=0x0000_0001, shamt=0 -> 0x0000_0001 with the same 5-stage latency. Then SLL shamt=31 -> 0x8000_0000.
4. ROR in_a=0x1234_5678, shamt=8 -> 0x7812_3456. Then back-to-back requests with in_valid always high -> accepts exactly 7 cycles apart.
5. Backpressure: out_ready=0 for 3 cycles in OUT -> out_result and out_valid stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> IDLE next edge.
6. abort during stage 2 -> IDLE next edge, out_valid never asserts. Separately, rst_n low during stage 3 -> out_valid, busy and out_result 0 immediately (asynchronous), in_ready 1; the next request completes correctly after release.
